// File: rtl/r2_acc_pkg.sv
// Shared types and helpers for the ROACH2 accumulation sequencer.
// Holds the state encoding, the counter width and the zero-length saturation helper.
package r2_acc_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // A zero accumulation length from software means a single spectrum.
  function automatic logic [CNT_W-1:0] len_sat(input logic [CNT_W-1:0] len);
    return (len == '0) ? CNT_W'(1) : len;
  endfunction

endpackage

// File: rtl/r2_acc_cnt.sv
// Channel/spectrum counter pair. The flags describe the sample currently presented,
// and clr_i makes that sample channel 0 of spectrum 0 before it is counted.
module r2_acc_cnt
  import r2_acc_pkg::*;
#(
  parameter int SPEC_LEN = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             chan_zero_o,
  output logic             first_o,
  output logic             last_o,
  output logic             wrap_o
);

  localparam int CH_W = $clog2(SPEC_LEN);

  logic [CH_W-1:0]  chan_q, chan_d, chan_eff;
  logic [CNT_W-1:0] spec_q, spec_d, spec_eff;

  assign chan_eff    = clr_i ? '0 : chan_q;
  assign spec_eff    = clr_i ? '0 : spec_q;
  assign chan_zero_o = (chan_q == '0);
  assign first_o     = (spec_eff == '0);
  assign last_o      = (spec_eff == len_i - CNT_W'(1));
  assign wrap_o      = (chan_eff == CH_W'(SPEC_LEN - 1));

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    chan_d = chan_eff;
    spec_d = spec_eff;
    if (en_i) begin
      chan_d = chan_eff + CH_W'(1);
      if (wrap_o) begin
        spec_d = last_o ? '0 : spec_eff + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan_q <= '0;
      spec_q <= '0;
    end else begin
      chan_q <= chan_d;
      spec_q <= spec_d;
    end
  end

endmodule

// File: rtl/r2_acc_ctrl.sv
// Accumulation sequencer: arms on an arm edge, aligns integrations to sync and tags
// each sample for the vector accumulator with new/dump/end-of-integration flags.
module r2_acc_ctrl
  import r2_acc_pkg::*;
#(
  parameter int SPEC_LEN = 2048,
  parameter int DATA_W   = 36
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       acc_len,
  input  logic              arm,
  input  logic              sync_in,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              acc_new,
  output logic              acc_dump,
  output logic              acc_eoi,
  output logic [31:0]       acc_cnt,
  output logic              armed,
  output logic              sync_err
);

  state_e             state_q, state_d;
  logic               arm_q;
  logic [CNT_W-1:0]   len_q, len_d, len_eff;
  logic               sync_err_q, sync_err_d;
  logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [DATA_W-1:0]  data_q;
  logic               valid_q, new_q, dump_q, eoi_q, armed_q;

  logic arm_edge, start, in_run, resync, restart, smp;
  logic chan_zero, spec_first, spec_last, chan_wrap, eoi;

  assign arm_edge = arm & ~arm_q;
  // An arm edge wins over a same-cycle sync: the sample is dropped and we stay ARMED.
  assign start    = (state_q == ST_ARMED) & valid_in & sync_in & ~arm_edge;
  assign in_run   = (state_q == ST_RUN) & ~arm_edge;
  assign resync   = in_run & valid_in & sync_in & ~chan_zero;
  assign restart  = start | resync;
  assign smp      = valid_in & (start | in_run);
  assign len_eff  = restart ? len_sat(acc_len) : len_q;
  assign eoi      = spec_last & chan_wrap;

  r2_acc_cnt #(
    .SPEC_LEN (SPEC_LEN)
  ) u_cnt (
    .clk         (user_clk),
    .rst         (user_rst),
    .clr_i       (restart | arm_edge),
    .en_i        (smp),
    .len_i       (len_eff),
    .chan_zero_o (chan_zero),
    .first_o     (spec_first),
    .last_o      (spec_last),
    .wrap_o      (chan_wrap)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (arm_edge) state_d = ST_ARMED;
      ST_ARMED: if (start)    state_d = ST_RUN;
      ST_RUN:   if (arm_edge) state_d = ST_ARMED;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    len_d      = len_q;
    sync_err_d = sync_err_q;
    acc_cnt_d  = acc_cnt_q;
    // Length is sampled only at integration boundaries so mid-integration writes wait.
    if (restart || (smp && eoi)) begin
      len_d = len_sat(acc_len);
    end
    if (arm_edge) begin
      sync_err_d = 1'b0;
    end else if (resync) begin
      sync_err_d = 1'b1;
    end
    if (smp && eoi) begin
      acc_cnt_d = acc_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q    <= ST_IDLE;
      arm_q      <= 1'b0;
      len_q      <= CNT_W'(1);
      sync_err_q <= 1'b0;
      acc_cnt_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      new_q      <= 1'b0;
      dump_q     <= 1'b0;
      eoi_q      <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_q      <= arm;
      len_q      <= len_d;
      sync_err_q <= sync_err_d;
      acc_cnt_q  <= acc_cnt_d;
      data_q     <= data_in;
      valid_q    <= smp;
      new_q      <= smp & spec_first;
      dump_q     <= smp & spec_last;
      eoi_q      <= smp & eoi;
      armed_q    <= (state_q == ST_ARMED);
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign acc_new   = new_q;
  assign acc_dump  = dump_q;
  assign acc_eoi   = eoi_q;
  assign acc_cnt   = acc_cnt_q;
  assign armed     = armed_q;
  assign sync_err  = sync_err_q;

endmodule

// File: doc/r2_acc_ctrl.md
# r2_acc_ctrl

Accumulation sequencer for the ROACH2 spectrometer datapath, running in the user clock domain. It takes the software-written accumulation length from its OPB register and the spectrum sync/valid stream from the FFT. It aligns integrations to sync and tags each sample for the downstream vector accumulator: overwrite on the first spectrum, dump on the last. It also maintains the integration counter and error status read back by software.

## Interface
Parameters:
- `SPEC_LEN`, 2048: channels per spectrum; power of two, ≥2.
- `DATA_W`, 36: width of the data passthrough.

Ports:
- `user_clk`  in  1  sole clock.
- `user_rst`  in  1  reset, asynchronous, active-high.
- `acc_len`  in  32  spectra per integration, from register `user_data_out`; 0 is treated as 1.
- `arm`  in  1  level from the control register; a rising edge arms.
- `sync_in`  in  1  spectrum start; meaningful only while `valid_in`=1.
- `valid_in`  in  1  sample valid.
- `data_in`  in  DATA_W  sample.
- `data_out`  out  DATA_W  `data_in` delayed 1 cycle.
- `valid_out`  out  1  `valid_in` delayed 1 cycle; forced 0 unless RUN.
- `acc_new`  out  1  sample belongs to the first spectrum of an integration.
- `acc_dump`  out  1  sample belongs to the last spectrum of an integration.
- `acc_eoi`  out  1  final sample of an integration: last channel of the last spectrum.
- `acc_cnt`  out  32  completed integrations.
- `armed`  out  1  state is ARMED.
- `sync_err`  out  1  sticky misaligned-sync flag.

## Operation
- States: IDLE, ARMED, RUN.
- Transitions:
  - IDLE→ARMED on an `arm` rising edge.
  - ARMED→RUN on `sync_in`&`valid_in`.
  - An `arm` rising edge in RUN→ARMED; the current integration is abandoned.
- Edge detection: one internal register on `arm`.
- Arm/sync collision: an arm edge and sync in the same cycle give ARMED→RUN priority to the arm, so the state becomes ARMED.
- Counters:
  - `chan_cnt`, log2(SPEC_LEN) bits, wraps.
  - `spec_cnt`, 32 bits.
  - `len_q`: `acc_len` latched (0→1) at every integration start. Register changes mid-integration take effect at the next integration.
- In RUN, each valid sample:
  - `acc_new` = (`spec_cnt`==0).
  - `acc_dump` = (`spec_cnt`==`len_q`−1).
  - `acc_eoi` = `acc_dump` & (`chan_cnt`==SPEC_LEN−1).
  - Then `chan_cnt`++.
  - On channel wrap, `spec_cnt`++. If that sample was `acc_eoi`, `spec_cnt`←0, relatch `len_q`, and `acc_cnt`++ (wraps at 2^32).
- Entry sample: the one that causes ARMED→RUN is channel 0 of spectrum 0 (`acc_new`=1).
- Sync in RUN:
  - With `chan_cnt`==0 it is aligned and ignored.
  - With `chan_cnt`≠0: `sync_err`←1, the counters restart with this sample as channel 0 of spectrum 0, and `acc_cnt` is not incremented.
- `sync_err` clears only on reset or an `arm` rising edge.
- With `len_q`=1, `acc_new` and `acc_dump` are both 1 for every sample.
- Invalid cycles: counters hold; tag outputs are 0.

## Timing
- All outputs are registered; input→output latency is 1 cycle, so tags align with `data_out`/`valid_out`.
- `acc_cnt` updates in the same cycle that `acc_eoi` is asserted at the output.
- `armed` is asserted the cycle after the arm edge is registered, i.e. 2 cycles after `arm` rises.
- Reset:
  - State is IDLE.
  - All outputs are 0, including `data_out`, `acc_cnt` and `sync_err`.
  - Counters are 0 and `len_q`=1.
- Throughput is one sample per cycle, with no backpressure.

## Structure
- Package `r2_acc_pkg`:
  - State enum (IDLE=0, ARMED=1, RUN=2).
  - `CNT_W`=32.
  - Function `len_sat(len)`, which maps 0→1.
- Sub-module `r2_acc_cnt`: channel/spectrum counter pair with clear, enable, wrap and terminal-count outputs.
- The top level holds the FSM, edge detect, counter instance, pipeline and status.

## Test plan
Test bench uses SPEC_LEN=8.

1. Reset mid-RUN, then release → all outputs 0, IDLE; pulsed `acc_len`/`valid_in` ignored until armed.
2. `acc_len`=3; arm; sync at t0; continuous valid for 48 cycles → `acc_new` on samples 0–7 and 24–31, `acc_dump` on 16–23 and 40–47, `acc_eoi` on 23 and 47, `acc_cnt`=2, each 1 cycle after input.
3. `acc_len`=0 → behaves as 1: every valid sample has `acc_new`=`acc_dump`=1, `acc_eoi` every 8th sample.
4. `acc_len`=2; sync again at channel 5 during RUN → `sync_err`=1, that sample has `acc_new`=1 as channel 0, `acc_cnt` unchanged; an `arm` edge clears `sync_err`.
5. `acc_len` changed from 2 to 4 during spectrum 1 → current integration ends after 2 spectra; the next lasts 4.
6. `valid_in` toggled 1-0-1 with the 48-cycle pattern → tag sequence identical to scenario 2 in valid samples only; arm-edge and sync in the same cycle → state ARMED, not RUN.
